// File: rtl/ray_edge_scheduler.sv
// Shares one ray-crossing unit across a polygon edge table and folds its hits into an
// even-odd inside flag per query pixel. Optional macro RAY_HIT_COUNT_EN adds res_hits.
module ray_edge_scheduler #(
   parameter int MAX_EDGES = 16,
   parameter int UNIT_LAT  = 3
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [9:0]                     req_x,
   input  logic [9:0]                     req_y,
   output logic                           res_valid,
   output logic                           res_inside,
   input  logic                           edge_wr_en,
   input  logic [$clog2(MAX_EDGES)-1:0]   edge_wr_addr,
   input  logic [37:0]                    edge_wr_data,
   input  logic                           cnt_wr_en,
   input  logic [$clog2(MAX_EDGES+1)-1:0] cnt_wr_data,
   output logic                           cfg_err,
   output logic                           busy,
   output logic [37:0]                    cu_line,
   output logic [9:0]                     cu_x_pixel,
   output logic [9:0]                     cu_y_pixel,
   input  logic                           cu_hit
`ifdef RAY_HIT_COUNT_EN
   ,
   output logic [$clog2(MAX_EDGES+1)-1:0] res_hits
`endif
);

   localparam int AW = $clog2(MAX_EDGES);
   localparam int CW = $clog2(MAX_EDGES + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [UNIT_LAT-1:0] TAG_TOP = UNIT_LAT'(1) << (UNIT_LAT - 1);

   logic [1:0]          state;
   logic                ready_en;
   logic [CW-1:0]       edge_count;
   logic [CW-1:0]       count_eff;
   logic [CW-1:0]       idx;
   logic [37:0]         edge_tab [MAX_EDGES];
   logic [37:0]         first_edge;
   logic [UNIT_LAT-1:0] vld_p;
   logic                parity;
   logic                parity_nxt;
   logic                hit_top;
   logic                accept;
   logic                drain_done;

   function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] v);
      if (v > CW'(MAX_EDGES)) return CW'(MAX_EDGES);
      return v;
   endfunction

   assign req_ready  = ready_en && (state == IDLE);
   assign busy       = (state != IDLE);
   assign res_valid  = (state == DONE);
   assign accept     = req_valid && req_ready;
   assign count_eff  = cnt_wr_en ? clamp_count(cnt_wr_data) : edge_count;
   assign hit_top    = vld_p[UNIT_LAT-1] && cu_hit;
   assign parity_nxt = parity ^ hit_top;
   // The last tagged edge sits alone at the top of the tag chain on its return cycle.
   assign drain_done = ((vld_p & ~TAG_TOP) == '0);
   // An edge-0 write in the accept cycle must be seen by the query it starts.
   assign first_edge = (edge_wr_en && edge_wr_addr == '0) ? edge_wr_data : edge_tab[0];

   always_ff @(posedge clk) begin
      if (edge_wr_en && state == IDLE) edge_tab[edge_wr_addr] <= edge_wr_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         ready_en   <= 1'b0;
         edge_count <= '0;
         idx        <= '0;
         vld_p      <= '0;
         parity     <= 1'b0;
         res_inside <= 1'b0;
         cfg_err    <= 1'b0;
         cu_line    <= '0;
         cu_x_pixel <= '0;
         cu_y_pixel <= '0;
      end else begin
         ready_en <= 1'b1;
         cfg_err  <= (edge_wr_en || cnt_wr_en) && (state != IDLE);
         vld_p    <= (vld_p << 1) | UNIT_LAT'(state == ISSUE);
         if (cnt_wr_en && state == IDLE) edge_count <= clamp_count(cnt_wr_data);
         if (accept) parity <= 1'b0;
         else if (vld_p[UNIT_LAT-1]) parity <= parity_nxt;

         case (state)
            IDLE: begin
               if (accept) begin
                  cu_x_pixel <= req_x;
                  cu_y_pixel <= req_y;
                  if (count_eff == '0) begin
                     res_inside <= 1'b0;
                     state      <= DONE;
                  end else begin
                     cu_line <= first_edge;
                     idx     <= CW'(1);
                     state   <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (idx == edge_count) begin
                  cu_line <= '0;
                  state   <= DRAIN;
               end else begin
                  cu_line <= edge_tab[idx[AW-1:0]];
                  idx     <= idx + CW'(1);
               end
            end
            DRAIN: begin
               if (drain_done) begin
                  res_inside <= parity_nxt;
                  state      <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RAY_HIT_COUNT_EN
   logic [CW-1:0] hits;
   logic [CW-1:0] hits_nxt;

   assign hits_nxt = hits + CW'(hit_top);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hits     <= '0;
         res_hits <= '0;
      end else begin
         if (accept) hits <= '0;
         else hits <= hits_nxt;
         if (accept && count_eff == '0) res_hits <= '0;
         else if (state == DRAIN && drain_done) res_hits <= hits_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_ray_edge_scheduler.sv
// Bench for ray_edge_scheduler: a behavioural 3-cycle crossing unit feeds cu_hit, and each
// query result and its latency are compared with a direct even-odd count over a model table.
`timescale 1ns/1ps
module tb_ray_edge_scheduler;
   localparam int MAXE = 16;
   localparam int LAT  = 3;
   localparam int AW   = $clog2(MAXE);
   localparam int CW   = $clog2(MAXE + 1);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [9:0]    req_x = '0;
   logic [9:0]    req_y = '0;
   logic          res_valid;
   logic          res_inside;
   logic          edge_wr_en = 1'b0;
   logic [AW-1:0] edge_wr_addr = '0;
   logic [37:0]   edge_wr_data = '0;
   logic          cnt_wr_en = 1'b0;
   logic [CW-1:0] cnt_wr_data = '0;
   logic          cfg_err;
   logic          busy;
   logic [37:0]   cu_line;
   logic [9:0]    cu_x_pixel;
   logic [9:0]    cu_y_pixel;
   logic          cu_hit;
`ifdef RAY_HIT_COUNT_EN
   logic [CW-1:0] res_hits;
`endif

   ray_edge_scheduler #(.MAX_EDGES(MAXE), .UNIT_LAT(LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
      .res_valid(res_valid), .res_inside(res_inside),
      .edge_wr_en(edge_wr_en), .edge_wr_addr(edge_wr_addr), .edge_wr_data(edge_wr_data),
      .cnt_wr_en(cnt_wr_en), .cnt_wr_data(cnt_wr_data), .cfg_err(cfg_err), .busy(busy),
      .cu_line(cu_line), .cu_x_pixel(cu_x_pixel), .cu_y_pixel(cu_y_pixel), .cu_hit(cu_hit)
`ifdef RAY_HIT_COUNT_EN
      , .res_hits(res_hits)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [37:0] m_tab [MAXE];
   int          m_cnt = 0;

   // Leftward ray from the pixel; an edge counts when its half-open y span holds py
   // and its crossing x lies strictly left of px.
   function automatic bit hit_f(input logic [37:0] e, input int px, input int py);
      int  x1, y1, x2, y2;
      real xc;
      x1 = int'(e[37:28]); y1 = int'(e[27:19]);
      x2 = int'(e[18:9]);  y2 = int'(e[8:0]);
      if ((y1 <= py) == (y2 <= py)) return 1'b0;
      xc = real'(x1) + real'((py - y1) * (x2 - x1)) / real'(y2 - y1);
      return xc < real'(px);
   endfunction

   function automatic logic [37:0] pack(input int x1, input int y1, input int x2, input int y2);
      return {10'(x1), 9'(y1), 10'(x2), 9'(y2)};
   endfunction

   function automatic int ref_hits(input int px, input int py);
      int h = 0;
      for (int i = 0; i < m_cnt; i++) h += int'(hit_f(m_tab[i], px, py));
      return h;
   endfunction

   // Crossing unit: result of the edge on cu_line appears on cu_hit LAT cycles later;
   // idle (zero) lines return noise that the scheduler must ignore.
   logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
   always @(posedge clk) begin
      h0 <= (cu_line == '0) ? 1'($urandom) : hit_f(cu_line, int'(cu_x_pixel), int'(cu_y_pixel));
      h1 <= h0;
      h2 <= h1;
   end
   assign cu_hit = h2;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic write_edge(input int a, input logic [37:0] d);
      edge_wr_en = 1'b1; edge_wr_addr = AW'(a); edge_wr_data = d;
      @(posedge clk); #1;
      edge_wr_en = 1'b0;
      m_tab[a] = d;
   endtask

   task automatic write_cnt(input int v);
      cnt_wr_en = 1'b1; cnt_wr_data = CW'(v);
      @(posedge clk); #1;
      cnt_wr_en = 1'b0;
      m_cnt = (v > MAXE) ? MAXE : v;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      check({tag, "_ready"}, 64'(req_ready), 64'd1);
   endtask

   // inj>0: drop-test edge write driven inj cycles after accept. cw: count write on accept.
   task automatic run_query(input string tag, input int px, input int py,
                            input int inj, input bit cw, input int cv);
      int lat, h, bad;
      wait_ready(tag);
      if (cw) begin
         cnt_wr_en = 1'b1; cnt_wr_data = CW'(cv);
         m_cnt = (cv > MAXE) ? MAXE : cv;
      end
      req_valid = 1'b1; req_x = 10'(px); req_y = 10'(py);
      h = ref_hits(px, py);
      @(posedge clk); #1;
      req_valid = 1'b0; cnt_wr_en = 1'b0;
      lat = 1; bad = 0;
      while (lat < 200) begin
         if (inj > 0 && lat == inj) begin
            edge_wr_en = 1'b1; edge_wr_addr = AW'(3); edge_wr_data = pack(500, 0, 500, 400);
         end
         if (inj > 0 && lat == inj + 1) begin
            edge_wr_en = 1'b0;
            check({tag, "_cfg_err"}, 64'(cfg_err), 64'd1);
         end
         if (inj > 0 && lat == inj + 2) check({tag, "_cfg_err_end"}, 64'(cfg_err), 64'd0);
         if (res_valid) break;
         if (!busy || req_ready) bad++;
         @(posedge clk); #1; lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'((m_cnt == 0) ? 1 : 1 + m_cnt + LAT));
      check({tag, "_inside"}, 64'(res_inside), 64'(h % 2));
`ifdef RAY_HIT_COUNT_EN
      check({tag, "_hits"}, 64'(res_hits), 64'(h));
`endif
      check({tag, "_busy_ready"}, 64'(bad), 64'd0);
      @(posedge clk); #1;
      check({tag, "_pulse"}, 64'(res_valid), 64'd0);
      check({tag, "_hold"}, 64'(res_inside), 64'(h % 2));
   endtask

   task automatic back_to_back(input int px, input int py);
      int n, h;
      h = ref_hits(px, py);
      wait_ready("b2b");
      req_valid = 1'b1; req_x = 10'(px); req_y = 10'(py);
      n = 0;
      while (!res_valid && n < 200) begin @(posedge clk); #1; n++; end
      check("b2b_first_valid", 64'(res_valid), 64'd1);
      check("b2b_ready_in_done", 64'(req_ready), 64'd0);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
         if (n == 1) check("b2b_ready_after", 64'(req_ready), 64'd1);
         if (n == 2) begin
            check("b2b_second_accepted", 64'(busy), 64'd1);
            req_valid = 1'b0;
         end
      end while (!res_valid && n < 200);
      check("b2b_gap", 64'(n), 64'(2 + m_cnt + LAT));
      check("b2b_inside", 64'(res_inside), 64'(h % 2));
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int seen;
      logic [37:0] e;
      for (int i = 0; i < MAXE; i++) m_tab[i] = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_inside", 64'(res_inside), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cfg_err", 64'(cfg_err), 64'd0);
      check("rst_cu_line", 64'(cu_line), 64'd0);
      check("rst_cu_xy", 64'({cu_x_pixel, cu_y_pixel}), 64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_ready", 64'(req_ready), 64'd1);

      for (int i = 0; i < MAXE; i++) write_edge(i, '0);
      write_edge(0, pack(100, 100, 200, 100));
      write_edge(1, pack(200, 100, 200, 200));
      write_edge(2, pack(200, 200, 100, 200));
      write_edge(3, pack(100, 200, 100, 100));
      write_cnt(4);
      run_query("sq_inside", 150, 150, 0, 1'b0, 0);
      run_query("sq_right", 250, 150, 0, 1'b0, 0);
      run_query("sq_above", 150, 50, 0, 1'b0, 0);
      run_query("sq_cfg_drop", 150, 150, 2, 1'b0, 0);
      run_query("sq_requery", 150, 150, 0, 1'b0, 0);

      write_cnt(0);
      run_query("cnt_zero", 150, 150, 0, 1'b0, 0);
      run_query("cnt_on_accept", 150, 150, 0, 1'b1, 4);
      back_to_back(150, 150);

      for (int i = 0; i < MAXE; i++) begin
         do e = pack($urandom_range(0, 1023), $urandom_range(0, 511),
                     $urandom_range(0, 1023), $urandom_range(0, 511));
         while (e == '0);
         write_edge(i, e);
      end
      write_cnt($urandom_range(1, MAXE));
      for (int q = 0; q < 20; q++) begin
         run_query("rand", $urandom_range(0, 1023), $urandom_range(0, 511), 0,
                   1'($urandom_range(0, 2) == 0), $urandom_range(0, 31));
      end
      write_cnt(31);
      run_query("clamp_31", $urandom_range(0, 1023), $urandom_range(0, 511), 0, 1'b0, 0);

      write_cnt(4);
      wait_ready("abort");
      req_valid = 1'b1; req_x = 10'd150; req_y = 10'd150;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      #1;
      check("abort_res_valid", 64'(res_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_ready_low", 64'(req_ready), 64'd0);
      check("abort_cu_line", 64'(cu_line), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      m_cnt = 0;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (res_valid) seen++;
      end
      check("abort_no_result", 64'(seen), 64'd0);
      check("abort_ready", 64'(req_ready), 64'd1);
      check("abort_idle", 64'(busy), 64'd0);
      run_query("abort_count_zero", 150, 150, 0, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ray_edge_scheduler.md
Name: ray_edge_scheduler

Overview:
- Sequencer that shares one ray-crossing unit across a polygon's edge list to answer point-in-polygon queries.
- Holds up to MAX_EDGES packed edges and streams them into the unit one per cycle for each query pixel.
- Collects the unit's `hit` results and XORs them into an even-odd inside/outside flag.
- Sits between the fill/shading logic (requester) and the ray-crossing unit (`line`/`x_pixel`/`y_pixel` in, `hit` out, fixed 3-cycle latency).

Parameters:
- MAX_EDGES, 16, depth of the edge table (power of 2, ≥2); AW = $clog2(MAX_EDGES), CW = $clog2(MAX_EDGES+1).
- UNIT_LAT, 3, cycles from edge presented on `cu_line` to its `cu_hit`.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  query request
- req_ready  out  1  high only in IDLE
- req_x  in  10  query pixel x
- req_y  in  10  query pixel y
- res_valid  out  1  one-cycle result pulse
- res_inside  out  1  even-odd result; held until the next res_valid
- edge_wr_en  in  1  edge table write
- edge_wr_addr  in  AW  edge index
- edge_wr_data  in  38  packed edge: {x1[9:0], y1[8:0], x2[9:0], y2[8:0]}
- cnt_wr_en  in  1  edge count write
- cnt_wr_data  in  CW  number of active edges
- cfg_err  out  1  one-cycle pulse when a config write is dropped
- busy  out  1  high in any state other than IDLE
- cu_line  out  38  edge to the crossing unit
- cu_x_pixel  out  10  pixel x to the crossing unit
- cu_y_pixel  out  10  pixel y to the crossing unit
- cu_hit  in  1  crossing result from the unit

Behaviour:
- Reset values: req_ready=0 during reset and 1 after release; res_valid=0, res_inside=0, cfg_err=0, busy=0, cu_line=0, cu_x/y=0, edge_count=0. Edge table contents are not reset.
- FSM states:
  - IDLE → ISSUE on req_valid && req_ready, if edge_count>0. req_x/req_y are latched and parity is cleared.
  - IDLE → DONE on the same handshake if edge_count==0.
  - ISSUE: edge i is driven on cu_line at accept cycle T+1+i, with cu_x/cu_y = latched pixel. After edge_count-1 is issued → DRAIN.
  - DRAIN: wait until every issued edge has returned → DONE.
  - DONE: res_valid=1 for one cycle → IDLE.
- Hit tracking:
  - A UNIT_LAT-deep valid shift register is tagged on each issue.
  - cu_hit is sampled only when the tag exits; parity ^= cu_hit.
  - Untagged cycles are ignored.
- Latency:
  - res_valid is asserted at T+1+edge_count+UNIT_LAT, where T is the accept cycle.
  - With edge_count==0: res_valid at T+1 and res_inside=0.
- cu_line is driven as 0 when not issuing. A zero edge has an empty y range, so it never hits.
- Edge and count writes:
  - Accepted only in IDLE. A write in any other state is dropped and cfg_err pulses the next cycle.
  - A write on the same cycle as a request accept is taken. The new edge_count applies to that query.
  - cnt_wr_data > MAX_EDGES is clamped to MAX_EDGES.
  - edge_wr_en and cnt_wr_en may both be set in one cycle; both are performed.
- req_valid during busy is ignored; the requester holds it until req_ready.
- Asynchronous reset mid-query aborts it: no res_valid, FSM to IDLE, edge_count=0.

Optional Feature:
- Macro: RAY_HIT_COUNT_EN.
- Defined: adds output res_hits [CW-1:0], the total number of edges hit for the query. It is cleared at accept, valid with res_valid and held with res_inside; reset value 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Square edges (100,100)-(200,100), (200,100)-(200,200), (200,200)-(100,200), (100,200)-(100,100); cnt=4; query (150,150) accepted at T → res_valid at T+8, res_inside=1 (res_hits=1).
- Same table, query (250,150) → res_inside=0 (res_hits=2). Query (150,50) → res_inside=0 (res_hits=0).
- cnt=0, any query accepted at T → res_valid at T+1, res_inside=0. cnt_wr_data=31 with MAX_EDGES=16 → count 16, res_valid at T+20.
- edge_wr_en pulsed at T+2 during a query → cfg_err pulse at T+3. Table unchanged: re-query (150,150) still gives inside=1.
- Back-to-back req_valid held high → second accept exactly one cycle after the first res_valid. req_ready=0 throughout busy.
- reset_n low at T+4 of a 4-edge query → no res_valid; after release req_ready=1, busy=0, edge_count=0.
